regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Parametrised successor register file for the core pipeline: NumRead registered read ports, one write port, and a per-register busy scoreboard with reserve/commit handshake.
- Decode reserves a destination register.
- Writeback commits data to it.
- Reads of a busy source stall until the commit arrives; same-cycle commits are forwarded to readers.
- Sits between decode (fetch/reserve) and writeback (commit); the debug read path feeds memory store data.

Parameters:
DataSize, 32, register width in bits
AddrSize, 5, register address width; NumRegs = 2**AddrSize
NumRead, 2, number of read ports (1..4)
ZeroReg, 1, 1 = register 0 reads as zero, is never written and is never busy

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
rd_req  in  1  fetch request for all read ports this cycle
rd_addr  in  NumRead*AddrSize  source addresses; port i at [i*AddrSize +: AddrSize]
rd_data  out  NumRead*DataSize  registered read data; port i at [i*DataSize +: DataSize]
rd_valid  out  1  rd_data updated by an accepted fetch in the previous cycle
rd_stall  out  1  combinational; the current fetch is blocked by a busy source
rsv_en  in  1  reserve destination register (mark busy)
rsv_addr  in  AddrSize  register to reserve
wr_en  in  1  commit write
wr_addr  in  AddrSize  commit address
wr_data  in  DataSize  commit data
busy  out  NumRegs  scoreboard bit per register, registered
dbg_addr  in  AddrSize  asynchronous debug/store-data read address
dbg_data  out  DataSize  combinational array[dbg_addr]; no bypass; 0 for reg 0 when ZeroReg=1

Behaviour:
Reset (synchronous, dominates every other input, including mid-fetch or mid-reservation):
- All registers 0, busy all 0, rd_data 0, rd_valid 0.
- rd_stall is 0 while busy is all 0.

Stall term for port i with address a:
- hit_i = busy[a] && !(wr_en && wr_addr==a).
- rd_stall = rd_req && OR over i of hit_i.
- Stall uses busy as it stands before this cycle's rsv_en. A same-cycle reservation never stalls the same-cycle fetch.

Fetch (single-cycle latency):
- Accepted when rd_req && !rd_stall. Next edge: rd_valid=1 and rd_data_i = bypass value.
- Bypass value: wr_data if wr_en && wr_addr==a (and a is not a suppressed reg 0); otherwise array[a].
- Reg 0 with ZeroReg=1 always yields 0.
- If rd_req && rd_stall: rd_valid=0 next cycle, rd_data holds.
- If !rd_req: rd_valid=0, rd_data holds. Outputs are not zeroed.

Commit:
- wr_en writes array[wr_addr] and clears busy[wr_addr] at the edge.
- A commit to a non-busy register is legal and writes the data.
- With ZeroReg=1, wr_addr=0 is ignored.
- Commit and fetch proceed in the same cycle; neither has priority over the other.

Reserve:
- rsv_en sets busy[rsv_addr]. Reserving an already-busy register leaves it busy; there is no count.
- With ZeroReg=1, rsv_addr=0 is ignored.
- rsv_en and wr_en to the same address in one cycle: data is written and busy ends set (the new reservation wins).

Widths: all addresses are full-range; no out-of-range case exists.

Decomposition:
Shared package regfile_pkg:
- Default DataSize/AddrSize.
- NumRegs derivation.
- Port-slice helper constants.

Sub-module regfile_read_port:
- One instance per read port, built with generate.
- Inputs: addr, array word, busy bit, write bypass signals.
- Outputs: bypass value and hit_i.
- The top level owns the array, scoreboard, output registers and stall OR-reduction.

Test Plan:
1. Reset, then write r5=0xDEADBEEF with wr_en; next cycle rd_req with addr0=5, addr1=0 -> one cycle later rd_data0=0xDEADBEEF, rd_data1=0, rd_valid=1.
2. rsv r7, then rd_req on r7 -> rd_stall=1, rd_valid=0 next cycle. Commit r7=0x1234 while rd_req is held -> rd_stall=0 in the commit cycle; next cycle rd_data=0x1234 and busy[7]=0.
3. Same cycle: rsv_en r3 and wr_en r3=0x55 -> array[3]=0x55, busy[3]=1. rd_req r3 in the same cycle is not stalled and returns 0x55.
4. ZeroReg=1: wr r0=0xFFFF and rsv r0 -> busy[0]=0, dbg_data(r0)=0, fetch of r0 returns 0.
5. Assert reset while busy=0x80 and rd_req is active -> next cycle busy=0, rd_valid=0, rd_data=0, all registers read 0.
6. NumRead=3, DataSize=16 build: fetch r1/r2/r3 preloaded with 0x0001/0x0002/0x0003 -> each port returns its own value in the correct slice.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared defaults and helpers for the register file with busy scoreboard.
//   DefDataSize / DefAddrSize / DefNumRead : default widths and port count
//   num_regs()  : number of architectural registers for an address width
//   slice_lo()  : low bit of port N inside a packed multi-port bus
package regfile_pkg;

  localparam int unsigned DefDataSize = 32;
  localparam int unsigned DefAddrSize = 5;
  localparam int unsigned DefNumRead  = 2;

  function automatic int unsigned num_regs(input int unsigned addr_size);
    return 32'd1 << addr_size;
  endfunction

  function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port
// Combinational per-port logic: selects the value a fetch returns (commit
// bypass or stored word) and flags whether this source blocks the fetch.
//   addr_i     : source register address
//   word_i     : stored array word at addr_i
//   busy_i     : scoreboard bit of addr_i
//   wr_en_i / wr_addr_i / wr_data_i : this cycle's commit
//   value_o    : data the fetch returns for this port
//   hit_o      : source is busy and not being committed this cycle
module regfile_read_port #(
  parameter int unsigned DataSize = 32,
  parameter int unsigned AddrSize = 5,
  parameter bit          ZeroReg  = 1'b1
) (
  input  logic [AddrSize-1:0] addr_i,
  input  logic [DataSize-1:0] word_i,
  input  logic                busy_i,
  input  logic                wr_en_i,
  input  logic [AddrSize-1:0] wr_addr_i,
  input  logic [DataSize-1:0] wr_data_i,
  output logic [DataSize-1:0] value_o,
  output logic                hit_o
);

  logic is_zero;
  logic wr_match;

  assign is_zero  = ZeroReg && (addr_i == '0);
  assign wr_match = wr_en_i && (wr_addr_i == addr_i);

  // A commit landing this cycle resolves the busy source, so it never blocks.
  assign hit_o   = busy_i && !wr_match;
  assign value_o = is_zero  ? '0 :
                   wr_match ? wr_data_i : word_i;

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Register file with NumRead registered read ports, one commit port and a
// per-register busy scoreboard (reserve at decode, clear at writeback).
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   rd_req / rd_addr    : fetch request and packed source addresses
//   rd_data / rd_valid  : registered fetch result, valid for one cycle
//   rd_stall            : current fetch blocked by a busy source
//   rsv_en / rsv_addr   : mark a destination register busy
//   wr_en / wr_addr / wr_data : commit data and clear busy
//   busy                : registered scoreboard
//   dbg_addr / dbg_data : unbypassed combinational array read
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DataSize = DefDataSize,
  parameter int unsigned AddrSize = DefAddrSize,
  parameter int unsigned NumRead  = DefNumRead,
  parameter bit          ZeroReg  = 1'b1,
  localparam int unsigned NumRegs = num_regs(AddrSize)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         rd_req,
  input  logic [NumRead*AddrSize-1:0]  rd_addr,
  output logic [NumRead*DataSize-1:0]  rd_data,
  output logic                         rd_valid,
  output logic                         rd_stall,
  input  logic                         rsv_en,
  input  logic [AddrSize-1:0]          rsv_addr,
  input  logic                         wr_en,
  input  logic [AddrSize-1:0]          wr_addr,
  input  logic [DataSize-1:0]          wr_data,
  output logic [NumRegs-1:0]           busy,
  input  logic [AddrSize-1:0]          dbg_addr,
  output logic [DataSize-1:0]          dbg_data
);

  logic [DataSize-1:0]         regs_q [NumRegs];
  logic [NumRegs-1:0]          busy_q, busy_d;
  logic [NumRead*DataSize-1:0] rd_data_q, rd_data_d;
  logic                        rd_valid_q;
  logic [NumRead*DataSize-1:0] byp_value;
  logic [NumRead-1:0]          hit;
  logic                        wr_ok, rsv_ok, accept;

  // Register 0 is hard-wired when ZeroReg is set: no writes, no reservations.
  assign wr_ok  = wr_en  && !(ZeroReg && (wr_addr  == '0));
  assign rsv_ok = rsv_en && !(ZeroReg && (rsv_addr == '0));

  for (genvar i = 0; i < NumRead; i++) begin : g_port
    logic [AddrSize-1:0] src;
    assign src = rd_addr[slice_lo(i, AddrSize) +: AddrSize];

    regfile_read_port #(
      .DataSize (DataSize),
      .AddrSize (AddrSize),
      .ZeroReg  (ZeroReg)
    ) u_port (
      .addr_i    (src),
      .word_i    (regs_q[src]),
      .busy_i    (busy_q[src]),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .value_o   (byp_value[slice_lo(i, DataSize) +: DataSize]),
      .hit_o     (hit[i])
    );
  end

  // Stall looks at busy_q only, so a same-cycle reservation cannot block it.
  assign rd_stall = rd_req && (|hit);
  assign accept   = rd_req && !rd_stall;

  always_comb begin
    busy_d    = busy_q;
    rd_data_d = rd_data_q;
    // Clear first, then set: a reservation in the commit cycle wins.
    if (wr_ok)  busy_d[wr_addr]  = 1'b0;
    if (rsv_ok) busy_d[rsv_addr] = 1'b1;
    if (accept) rd_data_d = byp_value;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NumRegs; r++) regs_q[r] <= '0;
      busy_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_ok) regs_q[wr_addr] <= wr_data;
      busy_q     <= busy_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= accept;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign dbg_data = (ZeroReg && (dbg_addr == '0)) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  logic        clock;
  // Default build: 2 read ports, 32-bit data
  logic        reset, rd_req, rsv_en, wr_en, rd_valid, rd_stall;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [4:0]  rsv_addr, wr_addr, dbg_addr;
  logic [31:0] wr_data, busy, dbg_data;
  // Second build: 3 read ports, 16-bit data
  logic        b_reset, b_rd_req, b_rsv_en, b_wr_en, b_rd_valid, b_rd_stall;
  logic [14:0] b_rd_addr;
  logic [47:0] b_rd_data;
  logic [4:0]  b_rsv_addr, b_wr_addr, b_dbg_addr;
  logic [15:0] b_wr_data, b_dbg_data;
  logic [31:0] b_busy;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  logic [63:0] m_data;
  logic        m_valid;

  regfile_scoreboard dut (
    .clock(clock), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_stall(rd_stall),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  regfile_scoreboard #(.DataSize(16), .AddrSize(5), .NumRead(3), .ZeroReg(1'b1)) dut3 (
    .clock(clock), .reset(b_reset), .rd_req(b_rd_req), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_stall(b_rd_stall),
    .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .busy(b_busy), .dbg_addr(b_dbg_addr), .dbg_data(b_dbg_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 0; rd_req = 0; rd_addr = '0; rsv_en = 0; rsv_addr = '0;
    wr_en = 0; wr_addr = '0; wr_data = '0; dbg_addr = '0;
  endtask

  // Value a source returns this cycle: r0 is zero, a landing commit is forwarded.
  function automatic logic [31:0] src_val(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  function automatic bit blocked(input logic [4:0] a);
    return m_busy[a] && !(wr_en && wr_addr == a);
  endfunction

  // One clock: check combinational outputs, advance the model, check registers.
  task automatic cycle();
    bit stall;
    logic [4:0] a0, a1;
    #1;
    a0 = rd_addr[4:0];
    a1 = rd_addr[9:5];
    stall = rd_req && (blocked(a0) || blocked(a1));
    check("rd_stall", {63'd0, rd_stall}, {63'd0, stall});
    check("dbg_data", {32'd0, dbg_data}, (dbg_addr == 5'd0) ? 64'd0 : {32'd0, m_regs[dbg_addr]});
    if (reset) begin
      for (int r = 0; r < 32; r++) m_regs[r] = '0;
      m_busy = '0; m_data = '0; m_valid = 0;
    end else begin
      if (rd_req && !stall) begin
        m_data  = {src_val(a1), src_val(a0)};
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
      if (wr_en && wr_addr != 5'd0) begin
        m_regs[wr_addr] = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (rsv_en && rsv_addr != 5'd0) m_busy[rsv_addr] = 1'b1;
    end
    @(posedge clock);
    #1;
    check("rd_valid", {63'd0, rd_valid}, {63'd0, m_valid});
    check("rd_data", rd_data, m_data);
    check("busy", {32'd0, busy}, {32'd0, m_busy});
  endtask

  initial begin
    idle();
    reset = 1;
    b_reset = 1; b_rd_req = 0; b_rd_addr = '0; b_rsv_en = 0; b_rsv_addr = '0;
    b_wr_en = 0; b_wr_addr = '0; b_wr_data = '0; b_dbg_addr = '0;
    for (int r = 0; r < 32; r++) m_regs[r] = 'x;
    m_busy = 'x; m_data = 'x; m_valid = 0;

    // Three-port 16-bit build: each port returns its own value in its own slice
    @(posedge clock); #1;
    b_reset = 0;
    for (int r = 1; r <= 3; r++) begin
      b_wr_en = 1; b_wr_addr = 5'(r); b_wr_data = 16'(r);
      @(posedge clock); #1;
    end
    b_wr_en = 0;
    b_rd_req = 1; b_rd_addr = {5'd3, 5'd2, 5'd1}; b_dbg_addr = 5'd2;
    #1;
    check("t6_stall", {63'd0, b_rd_stall}, 64'd0);
    check("t6_dbg", {48'd0, b_dbg_data}, 64'h2);
    @(posedge clock); #1;
    b_rd_req = 0;
    check("t6_data", {16'd0, b_rd_data}, 64'h0003_0002_0001);
    check("t6_valid", {63'd0, b_rd_valid}, 64'd1);
    check("t6_busy", {32'd0, b_busy}, 64'd0);

    // Reset the main build
    cycle();
    cycle();

    // 1: write r5, then fetch r5 and r0
    idle(); wr_en = 1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    cycle();
    idle(); rd_req = 1; rd_addr = {5'd0, 5'd5};
    cycle();
    check("t1_data0", {32'd0, rd_data[31:0]}, 64'hDEADBEEF);
    check("t1_data1", {32'd0, rd_data[63:32]}, 64'd0);
    check("t1_valid", {63'd0, rd_valid}, 64'd1);

    // 2: reserve r7, fetch stalls, commit releases it
    idle(); rsv_en = 1; rsv_addr = 5'd7;
    cycle();
    idle(); rd_req = 1; rd_addr = {5'd0, 5'd7};
    #1;
    check("t2_stall", {63'd0, rd_stall}, 64'd1);
    cycle();
    check("t2_nvalid", {63'd0, rd_valid}, 64'd0);
    wr_en = 1; wr_addr = 5'd7; wr_data = 32'h1234;
    #1;
    check("t2_release", {63'd0, rd_stall}, 64'd0);
    cycle();
    check("t2_data", {32'd0, rd_data[31:0]}, 64'h1234);
    check("t2_busy7", {63'd0, busy[7]}, 64'd0);

    // 3: reserve and commit r3 together while fetching r3
    idle(); rsv_en = 1; rsv_addr = 5'd3; wr_en = 1; wr_addr = 5'd3; wr_data = 32'h55;
    rd_req = 1; rd_addr = {5'd3, 5'd3};
    #1;
    check("t3_stall", {63'd0, rd_stall}, 64'd0);
    cycle();
    check("t3_data", rd_data, 64'h0000_0055_0000_0055);
    check("t3_busy3", {63'd0, busy[3]}, 64'd1);
    idle(); dbg_addr = 5'd3;
    #1;
    check("t3_dbg", {32'd0, dbg_data}, 64'h55);

    // 4: r0 ignores writes and reservations
    idle(); wr_en = 1; wr_addr = 5'd0; wr_data = 32'hFFFF; rsv_en = 1; rsv_addr = 5'd0;
    rd_req = 1; rd_addr = {5'd0, 5'd0};
    cycle();
    check("t4_busy0", {63'd0, busy[0]}, 64'd0);
    check("t4_data", rd_data, 64'd0);
    idle(); dbg_addr = 5'd0;
    #1;
    check("t4_dbg", {32'd0, dbg_data}, 64'd0);

    // 5: reset while only r7 is busy and a fetch is active
    idle(); wr_en = 1; wr_addr = 5'd3; wr_data = 32'h77; rsv_en = 1; rsv_addr = 5'd7;
    cycle();
    check("t5_busy_pre", {32'd0, busy}, 64'h80);
    idle(); reset = 1; rd_req = 1; rd_addr = {5'd5, 5'd3};
    cycle();
    check("t5_busy", {32'd0, busy}, 64'd0);
    check("t5_valid", {63'd0, rd_valid}, 64'd0);
    check("t5_data", rd_data, 64'd0);
    for (int a = 0; a < 32; a++) begin
      idle(); dbg_addr = 5'(a);
      cycle();
      check("t5_reg", {32'd0, dbg_data}, 64'd0);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      idle();
      reset    = ($urandom_range(0, 59) == 0);
      rd_req   = ($urandom_range(0, 3) != 0);
      rd_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      if ($urandom_range(0, 7) == 0) rd_addr = 10'($urandom);
      rsv_en   = ($urandom_range(0, 3) == 0);
      rsv_addr = 5'($urandom_range(0, 7));
      wr_en    = ($urandom_range(0, 1) == 0);
      wr_addr  = 5'($urandom_range(0, 7));
      wr_data  = $urandom;
      dbg_addr = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
